mem_bus_arbiter: RTL and testbench

- Sits directly downstream of the multi-cycle RV32 core.
- Merges the core's instruction-fetch channel and data-memory channel onto one single-ported valid/ready memory bus.
- At most one bus transaction is outstanding at a time. Read responses are buffered and returned to whichever channel issued the request.
- Writes are posted: a write completes on bus acceptance and produces no response.

---
 rtl/mem_bus_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Merges the RV32 core's fetch and data channels onto one single-outstanding valid/ready bus.
// Define MEM_BUS_ARBITER_PERF_EN to build the fetch/data/stall performance counters.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic                inst_req_valid,
  output logic                inst_req_ready,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_valid,
  input  logic                inst_ready,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_req_ready,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_rdata_valid,
  input  logic                mem_rdata_ready,
  output logic                bus_req_valid,
  input  logic                bus_req_ready,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                bus_we,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  input  logic                bus_rsp_valid,
  output logic                bus_rsp_ready,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic [31:0]         perf_ifetch_cnt,
  output logic [31:0]         perf_dacc_cnt,
  output logic [31:0]         perf_stall_cnt
);

  typedef enum logic [7:0] {
    IDLE  = 8'b0000_0001,
    I_REQ = 8'b0000_0010,
    I_RSP = 8'b0000_0100,
    I_OUT = 8'b0000_1000,
    D_RD  = 8'b0001_0000,
    D_WR  = 8'b0010_0000,
    D_RSP = 8'b0100_0000,
    D_OUT = 8'b1000_0000
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    wstrb_d         = wstrb_q;
    rdata_d         = rdata_q;
    inst_req_ready  = 1'b0;
    mem_req_ready   = 1'b0;
    inst_valid      = 1'b0;
    mem_rdata_valid = 1'b0;
    bus_req_valid   = 1'b0;
    bus_we          = 1'b0;
    bus_rsp_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        // Writes beat reads, and any data access beats a fetch.
        if (mem_write) begin
          mem_req_ready = 1'b1;
          addr_d        = mem_addr;
          wdata_d       = mem_wdata;
          wstrb_d       = mem_wstrb;
          state_d       = D_WR;
        end else if (mem_read) begin
          mem_req_ready = 1'b1;
          addr_d        = mem_addr;
          state_d       = D_RD;
        end else if (inst_req_valid) begin
          inst_req_ready = 1'b1;
          addr_d         = inst_addr;
          state_d        = I_REQ;
        end
      end
      I_REQ, D_RD, D_WR: begin
        bus_req_valid = 1'b1;
        bus_we        = (state_q == D_WR);
        if (bus_req_ready) begin
          if (state_q == I_REQ)     state_d = I_RSP;
          else if (state_q == D_RD) state_d = D_RSP;
          else                      state_d = IDLE;
        end
      end
      I_RSP, D_RSP: begin
        bus_rsp_ready = 1'b1;
        if (bus_rsp_valid) begin
          rdata_d = bus_rdata;
          state_d = (state_q == I_RSP) ? I_OUT : D_OUT;
        end
      end
      I_OUT: begin
        inst_valid = 1'b1;
        if (inst_ready) state_d = IDLE;
      end
      D_OUT: begin
        mem_rdata_valid = 1'b1;
        if (mem_rdata_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_wdata  = wdata_q;
  assign bus_wstrb  = wstrb_q;
  assign inst_rdata = rdata_q;
  assign mem_rdata  = rdata_q;

`ifdef MEM_BUS_ARBITER_PERF_EN
  logic [31:0] ifetch_q, dacc_q, stall_q;
  logic        fetch_hs, data_hs, stall_cyc;

  assign fetch_hs  = (state_q == I_REQ) && bus_req_ready;
  assign data_hs   = ((state_q == D_RD) || (state_q == D_WR)) && bus_req_ready;
  assign stall_cyc = (bus_req_valid && !bus_req_ready) ||
                     (bus_rsp_ready && !bus_rsp_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      ifetch_q <= '0;
      dacc_q   <= '0;
      stall_q  <= '0;
    end else begin
      if (fetch_hs)  ifetch_q <= ifetch_q + 32'd1;
      if (data_hs)   dacc_q   <= dacc_q + 32'd1;
      if (stall_cyc) stall_q  <= stall_q + 32'd1;
    end
  end

  assign perf_ifetch_cnt = ifetch_q;
  assign perf_dacc_cnt   = dacc_q;
  assign perf_stall_cnt  = stall_q;
`else
  assign perf_ifetch_cnt = 32'd0;
  assign perf_dacc_cnt   = 32'd0;
  assign perf_stall_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: queue-based scoreboard checked by a negedge monitor,
// with a small bus slave model supporting request stalls and response suppression.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_addr;
  logic        inst_req_valid;
  logic        inst_req_ready;
  logic [31:0] inst_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_req_ready;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;
  logic        mem_rdata_ready;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rsp_valid;
  logic        bus_rsp_ready;
  logic [31:0] bus_rdata;
  logic [31:0] perf_ifetch_cnt;
  logic [31:0] perf_dacc_cnt;
  logic [31:0] perf_stall_cnt;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_addr(inst_addr), .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
    .inst_rdata(inst_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_req_ready(mem_req_ready),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid), .mem_rdata_ready(mem_rdata_ready),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_addr(bus_addr),
    .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_ready(bus_rsp_ready), .bus_rdata(bus_rdata),
    .perf_ifetch_cnt(perf_ifetch_cnt), .perf_dacc_cnt(perf_dacc_cnt),
    .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

`ifdef MEM_BUS_ARBITER_PERF_EN
  localparam logic [31:0] EXP_IFETCH = 32'd2;
  localparam logic [31:0] EXP_DACC   = 32'd2;
  localparam logic [31:0] EXP_STALL  = 32'd2;
`else
  localparam logic [31:0] EXP_IFETCH = 32'd0;
  localparam logic [31:0] EXP_DACC   = 32'd0;
  localparam logic [31:0] EXP_STALL  = 32'd0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bexp_t;

  bexp_t       bus_q[$];
  logic [31:0] inst_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] bus_data_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Bus slave configuration, owned by the stimulus process.
  int stall_cfg = 0;
  bit rsp_en    = 1'b1;
  int spur_req  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Bus slave: stalls each new request stall_cfg cycles, answers reads one cycle after handshake.
  initial begin : bus_model
    bit hs;
    bit in_req;
    int stall_cnt;
    int spur_done;
    in_req = 1'b0; stall_cnt = 0; spur_done = 0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = '0;
    forever begin
      @(negedge clk);
      hs = bus_req_valid && bus_req_ready && !bus_we && rsp_en && !rst;
      if (rst || (bus_req_valid && bus_req_ready)) in_req = 1'b0;
      @(posedge clk);
      #1;
      bus_rsp_valid = 1'b0;
      if (hs) begin
        bus_rsp_valid = 1'b1;
        bus_rdata     = (bus_data_q.size() > 0) ? bus_data_q.pop_front() : 32'h0;
      end else if (spur_done != spur_req) begin
        spur_done     = spur_req;
        bus_rsp_valid = 1'b1;
        bus_rdata     = 32'hBAD0_BAD0;
      end
      if (bus_req_valid) begin
        if (!in_req) begin
          in_req    = 1'b1;
          stall_cnt = stall_cfg;
        end
        bus_req_ready = (stall_cnt == 0);
        if (stall_cnt > 0) stall_cnt--;
      end else begin
        bus_req_ready = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_req_valid && bus_req_ready) begin
        if (bus_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL bus_unexpected: got request addr %h, required none", bus_addr);
        end else begin
          bexp_t e;
          e = bus_q.pop_front();
          chk("bus_addr", bus_addr, e.addr);
          chk("bus_we", {31'd0, bus_we}, {31'd0, e.we});
          if (e.we) begin
            chk("bus_wdata", bus_wdata, e.wdata);
            chk("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, e.wstrb});
          end
        end
      end
      if (inst_valid && inst_ready) begin
        if (inst_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL inst_unexpected: got %h, required no instruction", inst_rdata);
        end else chk("inst_rdata", inst_rdata, inst_q.pop_front());
      end
      if (mem_rdata_valid && mem_rdata_ready) begin
        if (mem_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL mem_unexpected: got %h, required no load data", mem_rdata);
        end else chk("mem_rdata", mem_rdata, mem_q.pop_front());
      end
      if (inst_valid && mem_rdata_valid) begin
        n_cmp++; n_bad++;
        $display("FAIL both_valid: got inst_valid=1 mem_rdata_valid=1, required exclusive");
      end
    end
  end

  task automatic wait_cond(input int which, input string nm);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      case (which)
        0:       hit = inst_req_ready;
        1:       hit = mem_req_ready;
        2:       hit = inst_valid;
        3:       hit = bus_rsp_ready;
        default: hit = mem_rdata_valid;
      endcase
    end
    if (!hit) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: got timeout after 40 cycles, required event", nm);
    end
  endtask

  task automatic wait_done(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      done = (bus_q.size() == 0) && (inst_q.size() == 0) && (mem_q.size() == 0);
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: got pending scoreboard entries, required drained", nm);
    end
    @(posedge clk); #1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int stall);
    bus_q.push_back('{addr: {a[31:2], 2'b00}, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
    bus_data_q.push_back(d);
    inst_q.push_back(d);
    stall_cfg = stall; inst_addr = a; inst_req_valid = 1'b1;
    wait_cond(0, "fetch_accept");
    @(posedge clk); #1;
    inst_req_valid = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d, input int stall);
    bus_q.push_back('{addr: {a[31:2], 2'b00}, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
    bus_data_q.push_back(d);
    mem_q.push_back(d);
    stall_cfg = stall; mem_addr = a; mem_read = 1'b1;
    wait_cond(1, "load_accept");
    @(posedge clk); #1;
    mem_read = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int stall);
    bus_q.push_back('{addr: {a[31:2], 2'b00}, we: 1'b1, wdata: d, wstrb: s});
    stall_cfg = stall; mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_write = 1'b1;
    wait_cond(1, "store_accept");
    @(posedge clk); #1;
    mem_write = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish by 200us, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int vc;
    rst = 1'b1; inst_addr = '0; inst_req_valid = 1'b0; inst_ready = 1'b1;
    mem_addr = '0; mem_read = 1'b0; mem_write = 1'b0; mem_wdata = '0; mem_wstrb = '0;
    mem_rdata_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req_valid", {31'd0, bus_req_valid}, 32'd0);
    chk("rst_bus_rsp_ready", {31'd0, bus_rsp_ready}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_mem_rdata_valid", {31'd0, mem_rdata_valid}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_inst_rdata", inst_rdata, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_perf_stall", perf_stall_cnt, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fetch on a zero-wait bus; data visible three edges after acceptance.
    bus_q.push_back('{addr: 32'h100, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
    bus_data_q.push_back(32'h0000_0013);
    inst_q.push_back(32'h0000_0013);
    inst_addr = 32'h100; inst_req_valid = 1'b1;
    wait_cond(0, "t1_accept");
    @(posedge clk); #1;
    inst_req_valid = 1'b0;
    @(negedge clk);
    chk("t1_bus_we", {31'd0, bus_we}, 32'd0);
    chk("t1_inst_valid_c1", {31'd0, inst_valid}, 32'd0);
    @(negedge clk);
    chk("t1_inst_valid_c2", {31'd0, inst_valid}, 32'd0);
    @(negedge clk);
    chk("t1_inst_valid_c3", {31'd0, inst_valid}, 32'd1);
    chk("t1_inst_rdata", inst_rdata, 32'h0000_0013);
    @(negedge clk);
    chk("t1_idle_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("t1_idle_bus_valid", {31'd0, bus_req_valid}, 32'd0);
    wait_done("t1_done");

    // Posted write with 3 stall cycles; unaligned address goes out aligned.
    store(32'h203, 32'hAB00_0000, 4'b1000, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_stall_valid", {31'd0, bus_req_valid}, 32'd1);
      chk("t2_stall_ready", {31'd0, bus_req_ready}, 32'd0);
      chk("t2_stall_addr", bus_addr, 32'h200);
      chk("t2_stall_wstrb", {28'd0, bus_wstrb}, 32'h8);
      chk("t2_stall_wdata", bus_wdata, 32'hAB00_0000);
    end
    @(negedge clk);
    chk("t2_hs_we", {31'd0, bus_we}, 32'd1);
    @(negedge clk);
    chk("t2_idle_bus_valid", {31'd0, bus_req_valid}, 32'd0);
    chk("t2_no_rsp_ready", {31'd0, bus_rsp_ready}, 32'd0);
    chk("t2_no_mem_valid", {31'd0, mem_rdata_valid}, 32'd0);
    wait_done("t2_done");

    // Simultaneous load and fetch: data wins, fetch waits for load consumption.
    bus_q.push_back('{addr: 32'h40, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
    bus_q.push_back('{addr: 32'h8, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
    bus_data_q.push_back(32'hDEAD_BEEF);
    bus_data_q.push_back(32'h1234_5678);
    mem_q.push_back(32'hDEAD_BEEF);
    inst_q.push_back(32'h1234_5678);
    stall_cfg = 0; mem_rdata_ready = 1'b0;
    mem_addr = 32'h40; mem_read = 1'b1; inst_addr = 32'h8; inst_req_valid = 1'b1;
    wait_cond(1, "t3_load_accept");
    chk("t3_fetch_blocked_accept", {31'd0, inst_req_ready}, 32'd0);
    @(posedge clk); #1;
    mem_read = 1'b0;
    vc = 0;
    for (int i = 0; i < 20 && vc < 2; i++) begin
      @(negedge clk);
      chk("t3_fetch_blocked", {31'd0, inst_req_ready}, 32'd0);
      if (mem_rdata_valid) vc++;
    end
    if (vc < 2) begin
      n_cmp++; n_bad++;
      $display("FAIL t3_load_valid: got %0d valid cycles, required 2", vc);
    end
    chk("t3_load_data_held", mem_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    mem_rdata_ready = 1'b1;
    @(negedge clk);
    chk("t3_fetch_blocked_out", {31'd0, inst_req_ready}, 32'd0);
    wait_cond(0, "t3_fetch_accept");
    @(posedge clk); #1;
    inst_req_valid = 1'b0;
    wait_done("t3_done");

    // Core backpressure on the fetch response.
    inst_ready = 1'b0;
    fetch(32'h300, 32'hCAFE_F00D, 0);
    wait_cond(2, "t4_inst_valid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", {31'd0, inst_valid}, 32'd1);
      chk("t4_hold_data", inst_rdata, 32'hCAFE_F00D);
      chk("t4_bus_idle", {31'd0, bus_req_valid}, 32'd0);
    end
    @(posedge clk); #1;
    inst_ready = 1'b1;
    wait_done("t4_done");

    // Reset while waiting for a fetch response; the slave abandons it.
    rsp_en = 1'b0;
    bus_q.push_back('{addr: 32'h400, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
    inst_addr = 32'h400; inst_req_valid = 1'b1;
    wait_cond(0, "t5_accept");
    @(posedge clk); #1;
    inst_req_valid = 1'b0;
    wait_cond(3, "t5_in_rsp");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    spur_req++;
    @(posedge clk); #1;
    rst = 1'b0; rsp_en = 1'b1;
    @(negedge clk);
    chk("t5_rsp_ready", {31'd0, bus_rsp_ready}, 32'd0);
    chk("t5_bus_valid", {31'd0, bus_req_valid}, 32'd0);
    chk("t5_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("t5_bus_addr", bus_addr, 32'd0);
    chk("t5_inst_rdata", inst_rdata, 32'd0);
    chk("t5_perf_ifetch", perf_ifetch_cnt, 32'd0);
    @(negedge clk);
    chk("t5_spurious_ignored", {31'd0, inst_valid}, 32'd0);
    chk("t5_latch_clear", inst_rdata, 32'd0);
    @(posedge clk); #1;

    // Post-reset traffic: 2 fetches, 1 load, 1 store, 2 request stall cycles.
    fetch(32'h500, 32'h1111_1111, 0);
    wait_done("t6_f0");
    fetch(32'h504, 32'h2222_2222, 1);
    wait_done("t6_f1");
    load(32'h600, 32'h3333_3333, 0);
    wait_done("t6_ld");
    store(32'h700, 32'h4444_4444, 4'hF, 1);
    wait_done("t6_st");
    chk("perf_ifetch", perf_ifetch_cnt, EXP_IFETCH);
    chk("perf_dacc", perf_dacc_cnt, EXP_DACC);
    chk("perf_stall", perf_stall_cnt, EXP_STALL);

    chk("end_bus_q_empty", bus_q.size(), 32'd0);
    chk("end_inst_q_empty", inst_q.size(), 32'd0);
    chk("end_mem_q_empty", mem_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
